// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer control path: SC/T/D widths,
// opcode numbering (D index = opcode) and instruction-register field positions.
package mano_pkg;
  localparam int SC_W  = 3;
  localparam int T_W   = 1 << SC_W;
  localparam int D_W   = 8;
  localparam int IR_W  = 16;

  localparam int I_BIT  = 15;
  localparam int OP_MSB = 14;
  localparam int OP_LSB = 12;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  typedef logic [SC_W-1:0] sc_t;
  typedef logic [T_W-1:0]  tsig_t;
endpackage

// File: rtl/timing_sequencer_if.sv
// Control-stage bundle: master drives run/clear/IR/interrupt inputs,
// slave (the sequencer) returns timing, decode and state outputs.
interface timing_sequencer_if;
  import mano_pkg::*;

  logic            start;
  logic            hlt;
  logic            sc_clr;
  logic [IR_W-1:0] ir;
  logic            ien;
  logic            fgi;
  logic            fgo;
  logic [T_W-1:0]  T;
  logic [D_W-1:0]  D;
  logic            I;
  logic            run;
  logic [SC_W-1:0] sc;
  logic            r;

  modport master (
    output start, hlt, sc_clr, ir, ien, fgi, fgo,
    input  T, D, I, run, sc, r
  );

  modport slave (
    input  start, hlt, sc_clr, ir, ien, fgi, fgo,
    output T, D, I, run, sc, r
  );
endinterface

// File: rtl/timing_sequencer_decoder3to8.sv
// 3-bit binary to one-hot decoder with enable; purely combinational,
// output all-zero when disabled.
module decoder3to8
  import mano_pkg::*;
(
  input  logic            en_i,
  input  logic [SC_W-1:0] sel_i,
  output logic [T_W-1:0]  y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// Run flag, sequence counter, one-hot T, and T2 latch of D/I; start->T0 one cycle, no backpressure.
// Interrupt flip-flop R and the RT0-RT2 cycle exist only when MANO_INTERRUPT_EN is defined.
module timing_sequencer
  import mano_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  timing_sequencer_if.slave  seq_if
);

  logic           run_q, run_d;
  sc_t            sc_q, sc_d;
  logic [D_W-1:0] d_q, d_d;
  logic           i_q, i_d;
  logic           r_q, r_d;

  tsig_t          t_w;
  logic [D_W-1:0] d_load;
  logic           latch_ir;
  logic           r_set;
  logic           rt2_clr;
  logic           unused_ir;

  decoder3to8 u_t_dec (
    .en_i  (run_q),
    .sel_i (sc_q),
    .y_o   (t_w)
  );

  decoder3to8 u_d_dec (
    .en_i  (1'b1),
    .sel_i (seq_if.ir[OP_MSB:OP_LSB]),
    .y_o   (d_load)
  );

  assign unused_ir = ^seq_if.ir[OP_LSB-1:0];

`ifdef MANO_INTERRUPT_EN
  // R may only be raised outside T0-T2 so it never disturbs a fetch/decode in flight.
  assign r_set   = run_q & ~t_w[0] & ~t_w[1] & ~t_w[2] & seq_if.ien & (seq_if.fgi | seq_if.fgo);
  assign rt2_clr = run_q & r_q & t_w[2];
`else
  logic unused_intr;
  assign unused_intr = seq_if.ien ^ seq_if.fgi ^ seq_if.fgo;
  assign r_set   = 1'b0;
  assign rt2_clr = 1'b0;
`endif

  assign latch_ir = run_q & t_w[2] & ~r_q;

  always_comb begin
    run_d = run_q;
    sc_d  = sc_q;
    d_d   = d_q;
    i_d   = i_q;
    r_d   = r_q;

    if (seq_if.hlt) begin
      run_d = 1'b0;
    end else if (seq_if.start) begin
      run_d = 1'b1;
    end

    if (!run_q) begin
      if (seq_if.start) begin
        sc_d = '0;
      end
    end else if (seq_if.sc_clr || rt2_clr) begin
      sc_d = '0;
    end else begin
      sc_d = sc_q + 1'b1;
    end

    if (latch_ir) begin
      d_d = d_load;
      i_d = seq_if.ir[I_BIT];
    end

    if (r_set) begin
      r_d = 1'b1;
    end else if (rt2_clr) begin
      r_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      sc_q  <= '0;
      d_q   <= '0;
      i_q   <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      d_q   <= d_d;
      i_q   <= i_d;
      r_q   <= r_d;
    end
  end

  assign seq_if.T   = t_w;
  assign seq_if.D   = d_q;
  assign seq_if.I   = i_q;
  assign seq_if.run = run_q;
  assign seq_if.sc  = sc_q;
  assign seq_if.r   = r_q;

endmodule
